// File: rtl/ecg_buf_pkg.sv
// rtl/ecg_buf_pkg.sv - shared constants, bank index type and clog2 helper for the ECG frame buffer
package ecg_buf_pkg;

  localparam int NB_DEF        = 2;
  localparam int AW_DEF        = 12;
  localparam int DW_DEF        = 32;
  localparam int FRAME_LEN_DEF = 4096;

  // Wide enough for the largest supported ring (8 banks).
  typedef logic [2:0] bank_idx_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ecg_bank_switcher_if.sv
// rtl/ecg_bank_switcher_if.sv - flattened A/B port bus of the NB dual-port BRAM banks
interface ecg_bank_switcher_if #(
  parameter int NB = 2,
  parameter int AW = 12,
  parameter int DW = 32
);

  logic [NB*AW-1:0] bank_addra;
  logic [NB-1:0]    bank_wea;
  logic [NB*DW-1:0] bank_dina;
  logic [NB*AW-1:0] bank_addrb;
  logic [NB-1:0]    bank_enb;
  logic [NB*DW-1:0] bank_doutb;

  modport master (
    output bank_addra, bank_wea, bank_dina,
    output bank_addrb, bank_enb,
    input  bank_doutb
  );

  modport slave (
    input  bank_addra, bank_wea, bank_dina,
    input  bank_addrb, bank_enb,
    output bank_doutb
  );

endinterface

// File: rtl/ecg_ring_ptr.sv
// rtl/ecg_ring_ptr.sv - bank ring pointer, steps 0..NB-1 and wraps on advance
module ecg_ring_ptr import ecg_buf_pkg::*; #(
  parameter  int NB = NB_DEF,
  localparam int W  = clog2(NB)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == W'(NB - 1)) ? '0 : ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ecg_bank_switcher.sv
// rtl/ecg_bank_switcher.sv - NB-bank ring frame buffer controller between ECG front-end and reader
module ecg_bank_switcher import ecg_buf_pkg::*; #(
  parameter  int NB        = NB_DEF,
  parameter  int AW        = AW_DEF,
  parameter  int DW        = DW_DEF,
  parameter  int FRAME_LEN = FRAME_LEN_DEF,
  parameter  int CW        = 16,
  localparam int BW        = clog2(NB),
  localparam int FW        = clog2(NB + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  output logic                       rd_frame_valid,
  output logic [BW-1:0]              rd_bank,
  input  logic                       rd_en,
  input  logic [AW-1:0]              rd_addr,
  output logic [DW-1:0]              rd_data,
  input  logic                       rd_done,
  output logic [FW-1:0]              full_cnt,
  output logic [CW-1:0]              drop_cnt,
  ecg_bank_switcher_if.master        bank
);

  logic [FW-1:0]    full_cnt_q, full_cnt_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [NB-1:0]    wea_q, wea_d;
  logic [NB*AW-1:0] addra_q, addra_d;
  logic [NB*DW-1:0] dina_q, dina_d;
  logic [BW-1:0]    rd_sel_q, rd_sel_d;
  logic             rd_vld_q, rd_vld_d;
  logic [DW-1:0]    rd_hold_q, rd_hold_d;

  logic [BW-1:0]    wr_ptr, rd_ptr;
  logic             accept, reject, frame_done, rd_release;
  logic [NB*AW-1:0] addrb;
  logic [NB-1:0]    enb;
  logic [DW-1:0]    rd_mux;

  assign wr_ready       = (full_cnt_q != FW'(NB));
  assign rd_frame_valid = (full_cnt_q != '0);
  assign accept         = wr_valid && wr_ready;
  assign reject         = wr_valid && !wr_ready;
  assign frame_done     = accept && (wr_addr_q == AW'(FRAME_LEN - 1));
  assign rd_release     = rd_done && rd_frame_valid;

  ecg_ring_ptr #(.NB(NB)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (frame_done),
    .ptr     (wr_ptr)
  );

  ecg_ring_ptr #(.NB(NB)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (rd_release),
    .ptr     (rd_ptr)
  );

  // A completion and a release in the same cycle cancel out.
  always_comb begin
    full_cnt_d = full_cnt_q;
    case ({frame_done, rd_release})
      2'b10:   full_cnt_d = full_cnt_q + FW'(1);
      2'b01:   full_cnt_d = full_cnt_q - FW'(1);
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (reject && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CW'(1);
    wr_addr_d = wr_addr_q;
    if (accept) wr_addr_d = frame_done ? '0 : wr_addr_q + AW'(1);
  end

  always_comb begin
    wea_d   = '0;
    addra_d = addra_q;
    dina_d  = dina_q;
    for (int b = 0; b < NB; b++) begin
      if (accept && (wr_ptr == BW'(b))) begin
        wea_d[b]             = 1'b1;
        addra_d[b*AW +: AW]  = wr_addr_q;
        dina_d[b*DW +: DW]   = wr_data;
      end
    end
  end

  // Read side: only the bank under rd_ptr sees the reader's address and strobe.
  always_comb begin
    addrb  = '0;
    enb    = '0;
    rd_mux = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_ptr == BW'(b)) begin
        addrb[b*AW +: AW] = rd_addr;
        enb[b]            = rd_en && rd_frame_valid;
      end
      if (rd_sel_q == BW'(b)) rd_mux = bank.bank_doutb[b*DW +: DW];
    end
  end

  // The bank select is captured with the strobe so a coincident rd_done cannot redirect the data.
  always_comb begin
    rd_vld_d  = rd_en && rd_frame_valid;
    rd_sel_d  = rd_vld_d ? rd_ptr : rd_sel_q;
    rd_hold_d = rd_vld_q ? rd_mux : rd_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_cnt_q <= '0;
      drop_cnt_q <= '0;
      wr_addr_q  <= '0;
      wea_q      <= '0;
      addra_q    <= '0;
      dina_q     <= '0;
      rd_sel_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      full_cnt_q <= full_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      wr_addr_q  <= wr_addr_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      rd_sel_q   <= rd_sel_d;
      rd_vld_q   <= rd_vld_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  assign rd_data         = rd_vld_q ? rd_mux : rd_hold_q;
  assign rd_bank         = rd_ptr;
  assign full_cnt        = full_cnt_q;
  assign drop_cnt        = drop_cnt_q;
  assign bank.bank_wea   = wea_q;
  assign bank.bank_addra = addra_q;
  assign bank.bank_dina  = dina_q;
  assign bank.bank_addrb = addrb;
  assign bank.bank_enb   = enb;

endmodule

// File: tb/tb_ecg_bank_switcher.sv
// tb/tb_ecg_bank_switcher.sv - directed bench: NB=2 ping-pong vector table plus NB=3 ring sequences
module tb_ecg_bank_switcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // NB=2, FRAME_LEN=4 instance
  logic        rst2, wv2, re2, rdn2;
  logic [31:0] wd2, rdata2;
  logic [3:0]  ra2;
  logic        rdy2, fv2, rb2;
  logic [1:0]  full2;
  logic [15:0] drop2;

  ecg_bank_switcher_if #(.NB(2), .AW(4), .DW(32)) bif2 ();

  ecg_bank_switcher #(.NB(2), .AW(4), .DW(32), .FRAME_LEN(4), .CW(16)) u_dut2 (
    .clk(clk), .rst(rst2), .wr_valid(wv2), .wr_data(wd2), .wr_ready(rdy2),
    .rd_frame_valid(fv2), .rd_bank(rb2), .rd_en(re2), .rd_addr(ra2), .rd_data(rdata2),
    .rd_done(rdn2), .full_cnt(full2), .drop_cnt(drop2), .bank(bif2)
  );

  logic [31:0] mem2 [2][16];
  logic [31:0] dout2 [2];
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bif2.bank_wea[b]) mem2[b][bif2.bank_addra[b*4 +: 4]] <= bif2.bank_dina[b*32 +: 32];
      if (bif2.bank_enb[b]) dout2[b] <= mem2[b][bif2.bank_addrb[b*4 +: 4]];
    end
  end
  assign bif2.bank_doutb = {dout2[1], dout2[0]};

  // NB=3, FRAME_LEN=2, 2-bit drop counter instance
  logic        rst3, wv3, re3, rdn3;
  logic [31:0] wd3, rdata3;
  logic [3:0]  ra3;
  logic        rdy3, fv3;
  logic [1:0]  rb3, full3, drop3;

  ecg_bank_switcher_if #(.NB(3), .AW(4), .DW(32)) bif3 ();

  ecg_bank_switcher #(.NB(3), .AW(4), .DW(32), .FRAME_LEN(2), .CW(2)) u_dut3 (
    .clk(clk), .rst(rst3), .wr_valid(wv3), .wr_data(wd3), .wr_ready(rdy3),
    .rd_frame_valid(fv3), .rd_bank(rb3), .rd_en(re3), .rd_addr(ra3), .rd_data(rdata3),
    .rd_done(rdn3), .full_cnt(full3), .drop_cnt(drop3), .bank(bif3)
  );

  assign bif3.bank_doutb = '0;

  typedef struct packed {
    logic        wv;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic        rdn;
    logic        rdy;
    logic        fv;
    logic [1:0]  full;
    logic [15:0] drop;
    logic        rb;
    logic [1:0]  wea;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  enb;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input int wv, wd, re, ra, rdn, rdy, fv, full, drop, rb,
                              wea, waddr, wdata, enb, rdata);
    vec_t v;
    v.wv = 1'(wv);     v.wd = 32'(wd);     v.re = 1'(re);       v.ra = 4'(ra);
    v.rdn = 1'(rdn);   v.rdy = 1'(rdy);    v.fv = 1'(fv);       v.full = 2'(full);
    v.drop = 16'(drop); v.rb = 1'(rb);     v.wea = 2'(wea);     v.waddr = 4'(waddr);
    v.wdata = 32'(wdata); v.enb = 2'(enb); v.rdata = 32'(rdata);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int bk;
    logic [7:0] exp_addrb;

    //   wv  wd re ra rdn | rdy fv full drop rb | wea waddr wdata | enb rdata
    vt[0]  = mk(1,  1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0,  0,  0, 0);
    vt[1]  = mk(1,  2, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0,  1,  0, 0);
    vt[2]  = mk(1,  3, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1,  2,  0, 0);
    vt[3]  = mk(1,  4, 0, 0, 0,  1, 0, 0, 0, 0,  1, 2,  3,  0, 0);
    vt[4]  = mk(1,  5, 0, 0, 0,  1, 1, 1, 0, 0,  1, 3,  4,  0, 0);
    vt[5]  = mk(1,  6, 0, 0, 0,  1, 1, 1, 0, 0,  2, 0,  5,  0, 0);
    vt[6]  = mk(1,  7, 0, 0, 0,  1, 1, 1, 0, 0,  2, 1,  6,  0, 0);
    vt[7]  = mk(1,  8, 0, 0, 0,  1, 1, 1, 0, 0,  2, 2,  7,  0, 0);
    vt[8]  = mk(1,  9, 0, 0, 0,  0, 1, 2, 0, 0,  2, 3,  8,  0, 0);
    vt[9]  = mk(1,  9, 0, 0, 0,  0, 1, 2, 1, 0,  0, 0,  0,  0, 0);
    vt[10] = mk(1,  9, 0, 0, 0,  0, 1, 2, 2, 0,  0, 0,  0,  0, 0);
    vt[11] = mk(0,  0, 1, 0, 0,  0, 1, 2, 3, 0,  0, 0,  0,  1, 0);
    vt[12] = mk(0,  0, 1, 1, 0,  0, 1, 2, 3, 0,  0, 0,  0,  1, 1);
    vt[13] = mk(0,  0, 1, 2, 0,  0, 1, 2, 3, 0,  0, 0,  0,  1, 2);
    vt[14] = mk(0,  0, 1, 3, 1,  0, 1, 2, 3, 0,  0, 0,  0,  1, 3);
    vt[15] = mk(0,  0, 0, 0, 0,  1, 1, 1, 3, 1,  0, 0,  0,  0, 4);
    vt[16] = mk(1, 10, 0, 0, 0,  1, 1, 1, 3, 1,  0, 0,  0,  0, 4);
    vt[17] = mk(1, 11, 0, 0, 0,  1, 1, 1, 3, 1,  1, 0, 10,  0, 4);
    vt[18] = mk(1, 12, 0, 0, 0,  1, 1, 1, 3, 1,  1, 1, 11,  0, 4);
    vt[19] = mk(1, 13, 0, 0, 1,  1, 1, 1, 3, 1,  1, 2, 12,  0, 4);
    vt[20] = mk(0,  0, 0, 0, 0,  1, 1, 1, 3, 0,  1, 3, 13,  0, 4);
    vt[21] = mk(1, 14, 0, 0, 0,  1, 1, 1, 3, 0,  0, 0,  0,  0, 4);
    vt[22] = mk(0,  0, 0, 0, 0,  1, 1, 1, 3, 0,  2, 0, 14,  0, 4);

    rst2 = 1'b1; wv2 = 1'b0; wd2 = '0; re2 = 1'b0; ra2 = '0; rdn2 = 1'b0;
    rst3 = 1'b1; wv3 = 1'b0; wd3 = '0; re3 = 1'b0; ra3 = '0; rdn3 = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst full",  32'(full2),  0);
    chk("rst drop",  32'(drop2),  0);
    chk("rst wea",   32'(bif2.bank_wea), 0);
    chk("rst addra", 32'(bif2.bank_addra), 0);
    chk("rst rdata", rdata2, 0);
    chk("rst rdy",   32'(rdy2), 1);
    chk("rst fv",    32'(fv2),  0);
    rst2 = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      wv2 = vt[i].wv; wd2 = vt[i].wd; re2 = vt[i].re; ra2 = vt[i].ra; rdn2 = vt[i].rdn;
      @(negedge clk);
      chk($sformatf("v%0d rdy", i),   32'(rdy2),  32'(vt[i].rdy));
      chk($sformatf("v%0d fv", i),    32'(fv2),   32'(vt[i].fv));
      chk($sformatf("v%0d full", i),  32'(full2), 32'(vt[i].full));
      chk($sformatf("v%0d drop", i),  32'(drop2), 32'(vt[i].drop));
      chk($sformatf("v%0d rbank", i), 32'(rb2),   32'(vt[i].rb));
      chk($sformatf("v%0d wea", i),   32'(bif2.bank_wea), 32'(vt[i].wea));
      chk($sformatf("v%0d enb", i),   32'(bif2.bank_enb), 32'(vt[i].enb));
      chk($sformatf("v%0d rdata", i), rdata2, vt[i].rdata);
      exp_addrb = 8'(vt[i].ra) << (4 * vt[i].rb);
      chk($sformatf("v%0d addrb", i), 32'(bif2.bank_addrb), 32'(exp_addrb));
      if (vt[i].wea[1]) begin
        chk($sformatf("v%0d addra1", i), 32'(bif2.bank_addra[7:4]), 32'(vt[i].waddr));
        chk($sformatf("v%0d dina1", i),  bif2.bank_dina[63:32], vt[i].wdata);
      end else if (vt[i].wea[0]) begin
        chk($sformatf("v%0d addra0", i), 32'(bif2.bank_addra[3:0]), 32'(vt[i].waddr));
        chk($sformatf("v%0d dina0", i),  bif2.bank_dina[31:0], vt[i].wdata);
      end
    end

    // Reset two samples into a frame on bank 1 (one sample already written at v21).
    @(posedge clk); #1;
    wv2 = 1'b1; wd2 = 32'd15;
    @(posedge clk); #1;
    wv2 = 1'b0; rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0; wv2 = 1'b1; wd2 = 32'h55;
    @(negedge clk);
    chk("mrst full",  32'(full2), 0);
    chk("mrst drop",  32'(drop2), 0);
    chk("mrst wea",   32'(bif2.bank_wea), 0);
    chk("mrst fv",    32'(fv2), 0);
    chk("mrst rbank", 32'(rb2), 0);
    chk("mrst rdata", rdata2, 0);
    @(posedge clk); #1;
    wv2 = 1'b0;
    @(negedge clk);
    chk("mrst wea2",  32'(bif2.bank_wea), 1);
    chk("mrst addra", 32'(bif2.bank_addra[3:0]), 0);
    chk("mrst dina",  bif2.bank_dina[31:0], 32'h55);

    // NB=3 ring: rd_done on an empty buffer is ignored.
    @(posedge clk); #1;
    rst3 = 1'b0; rdn3 = 1'b1;
    @(posedge clk); #1;
    rdn3 = 1'b0;
    @(negedge clk);
    chk("n3 idle rbank", 32'(rb3), 0);
    chk("n3 idle full",  32'(full3), 0);

    for (int f = 0; f < 4; f++) begin
      bk = f % 3;
      @(posedge clk); #1;
      wv3 = 1'b1; wd3 = 32'(f * 2 + 1);
      @(posedge clk); #1;
      wd3 = 32'(f * 2 + 2);
      @(negedge clk);
      chk($sformatf("n3 f%0d wea a", f), 32'(bif3.bank_wea), 32'(1 << bk));
      @(posedge clk); #1;
      wv3 = 1'b0;
      @(negedge clk);
      chk($sformatf("n3 f%0d wea b", f), 32'(bif3.bank_wea), 32'(1 << bk));
      chk($sformatf("n3 f%0d full", f),  32'(full3), 1);
      chk($sformatf("n3 f%0d fv", f),    32'(fv3), 1);
      chk($sformatf("n3 f%0d rbank", f), 32'(rb3), 32'(bk));
      @(posedge clk); #1;
      rdn3 = 1'b1;
      @(posedge clk); #1;
      rdn3 = 1'b0;
      @(negedge clk);
      chk($sformatf("n3 f%0d rel full", f),  32'(full3), 0);
      chk($sformatf("n3 f%0d rel rbank", f), 32'(rb3), 32'((f + 1) % 3));
      chk($sformatf("n3 f%0d rel fv", f),    32'(fv3), 0);
      rdn3 = 1'b1;
      @(posedge clk); #1;
      rdn3 = 1'b0;
      @(negedge clk);
      chk($sformatf("n3 f%0d ign rbank", f), 32'(rb3), 32'((f + 1) % 3));
      chk($sformatf("n3 f%0d ign full", f),  32'(full3), 0);
    end

    // Fill all three banks, then keep pushing: 5 rejects saturate the 2-bit counter at 3.
    @(posedge clk); #1;
    wv3 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wd3 = 32'(100 + k);
      @(posedge clk); #1;
    end
    wv3 = 1'b0;
    @(negedge clk);
    chk("n3 sat drop",  32'(drop3), 3);
    chk("n3 sat full",  32'(full3), 3);
    chk("n3 sat rdy",   32'(rdy3), 0);
    chk("n3 sat wea",   32'(bif3.bank_wea), 0);
    chk("n3 sat rbank", 32'(rb3), 1);
    @(posedge clk); #1;
    rdn3 = 1'b1;
    @(posedge clk); #1;
    rdn3 = 1'b0;
    @(negedge clk);
    chk("n3 rel full",  32'(full3), 2);
    chk("n3 rel rdy",   32'(rdy3), 1);
    chk("n3 rel rbank", 32'(rb3), 2);
    chk("n3 rdata",     rdata3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecg_bank_switcher.md
Name: ecg_bank_switcher

Overview:
- Parametrised N-bank ping-pong frame buffer controller between the ECG front-end sample stream and the analysis/readout logic.
- Drives the A port (write) and B port (read) of NB external dual-port BRAM banks.
- The writer fills banks in ring order; the reader consumes completed frames in the same order.
- Bank hand-over is automatic, on frame completion and reader release. No external switch signal is used.

Parameters:
- NB, 2, number of BRAM banks (2..8).
- AW, 12, bank address width.
- DW, 32, sample/data width.
- FRAME_LEN, 4096, samples per frame (2..2**AW).
- CW, 16, width of the dropped-sample counter.

Ports:
- clk  in  1  single system clock for all logic and both BRAM ports.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  front-end sample valid.
- wr_data  in  DW  front-end sample.
- wr_ready  out  1  a bank slot is free; sample accepted when wr_valid&&wr_ready.
- rd_frame_valid  out  1  at least one completed frame is available to the reader.
- rd_bank  out  $clog2(NB)  index of the bank currently presented to the reader.
- rd_en  in  1  read strobe for the current read bank.
- rd_addr  in  AW  read address within the frame.
- rd_data  out  DW  read data, 1 cycle after rd_en.
- rd_done  in  1  reader releases the current frame (1-cycle pulse).
- full_cnt  out  $clog2(NB+1)  number of completed, unreleased frames.
- drop_cnt  out  CW  saturating count of samples rejected while full.
- bank_addra  out  NB*AW  per-bank A address.
- bank_wea  out  NB  per-bank write enable.
- bank_dina  out  NB*DW  per-bank write data.
- bank_addrb  out  NB*AW  per-bank B address.
- bank_enb  out  NB  per-bank read enable.
- bank_doutb  in  NB*DW  per-bank read data (BRAM latency 1).

Behaviour:
- Reset values:
  - wr_ptr=0, rd_ptr=0, wr_addr=0, full_cnt=0, drop_cnt=0.
  - All bank_wea=0. All bank_addra/bank_dina registers=0.
  - rd_data register=0.
  - Reset mid-frame discards the partial frame and all completed frames.
- wr_ready = (full_cnt != NB), combinational.
- Accept (wr_valid&&wr_ready) has write latency 1. On the next cycle:
  - bank_wea[wr_ptr]=1, bank_addra[wr_ptr]=wr_addr, bank_dina[wr_ptr]=wr_data.
  - All other bank_wea bits are 0.
  - bank_wea/addra/dina are registered outputs.
- wr_addr increments per accept. At wr_addr==FRAME_LEN-1:
  - wr_addr wraps to 0.
  - wr_ptr advances (NB-1 wraps to 0).
  - full_cnt increments.
- Reject: wr_valid&&!wr_ready increments drop_cnt, saturating at 2**CW-1. The sample is lost and wr_addr is unchanged.
- rd_frame_valid = (full_cnt != 0). rd_bank = rd_ptr.
- Read port, combinational into BRAM:
  - bank_addrb[rd_ptr]=rd_addr.
  - bank_enb[rd_ptr]=rd_en&&rd_frame_valid.
  - All other bank_enb=0 and bank_addrb=0.
- rd_data: registered mux of bank_doutb selected by rd_ptr sampled on the rd_en cycle (rd_ptr_q). Data stays correct when rd_done coincides with the last rd_en.
- rd_done with rd_frame_valid:
  - rd_ptr advances mod NB.
  - full_cnt decrements.
- rd_done with !rd_frame_valid is ignored.
- Frame completion and rd_done in the same cycle: full_cnt is unchanged, and both pointers advance.
- Writes are never issued to a bank counted in full_cnt. This is guaranteed by the wr_ready gating.
- The read bank and the fill bank coincide only when full_cnt==0. In that case the reader is blocked by rd_frame_valid=0.
- NB=2 reproduces classic ping-pong operation with automatic swap.

Decomposition:
- Shared package ecg_buf_pkg holds:
  - Constants NB_DEF, AW_DEF, DW_DEF, FRAME_LEN_DEF.
  - Function clog2 and a bank-index typedef.
- One sub-module, ecg_ring_ptr: wrap-around pointer with advance input, parametrised on NB. It is instantiated twice, for wr_ptr and rd_ptr.
- The port muxing stays in the top module.

Test Plan:
- NB=2, FRAME_LEN=4: write samples 1..4 back-to-back.
  - Expect bank_wea[0] on cycles 2..5 at addresses 0..3.
  - Then full_cnt=1, rd_frame_valid=1, wr_ptr=1.
- Continue with 5..8 into bank 1 (full_cnt=2, wr_ready=0). Then present sample 9 for 3 cycles.
  - Expect drop_cnt=3 and no bank_wea.
  - Then pulse rd_done: expect wr_ready=1 and rd_bank=1.
- Read bank 0 with rd_addr 0..3, bank_doutb[0] returning 1..4.
  - Expect rd_data 1,2,3,4 one cycle after each rd_en.
  - Only bank_enb[0] is asserted.
  - rd_done on the last read still yields 4.
- Same-cycle last write and rd_done with full_cnt=1: full_cnt stays 1, and both wr_ptr and rd_ptr advance.
- NB=3 ring wrap: fill and release 4 frames.
  - Pointers follow 0,1,2,0.
  - rd_done pulsed while full_cnt=0 is ignored.
- Assert rst after 2 samples of a frame.
  - Next cycle: full_cnt=0, drop_cnt=0, bank_wea=0.
  - The next sample is written to bank 0, address 0.
